// File: rtl/mem_merge_router.sv
// N-to-1 memory request merger: arbitrates PORTS request streams onto one registered output,
// tags requests with their source port, routes read responses back, and limits in-flight reads per port.

module mem_merge_port_cnt #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] cnt;

  // Simultaneous inc/dec cancel; a response with nothing outstanding leaves the count at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             cnt <= '0;
    else if (inc && !dec)                cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign full = (cnt == CW'(MAX_OUTSTANDING));
endmodule

module mem_merge_router #(
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter  int ID_WIDTH        = 1,
  parameter  int PORTS           = 4,
  parameter  int ARB_MODE        = 1,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int PORT_W          = $clog2(PORTS),
  localparam int OUT_ID_WIDTH    = ID_WIDTH + PORT_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PORTS-1:0]                     mem_in_valid,
  output logic [PORTS-1:0]                     mem_in_ready,
  input  logic [PORTS-1:0]                     mem_in_read_enable,
  input  logic [PORTS-1:0][ADDR_WIDTH-1:0]     mem_in_address,
  input  logic [PORTS-1:0][DATA_WIDTH-1:0]     mem_in_data,
  input  logic [PORTS-1:0][MASK_WIDTH-1:0]     mem_in_write_mask,
  input  logic [PORTS-1:0][ID_WIDTH-1:0]       mem_in_id,
  output logic                                 mem_out_valid,
  input  logic                                 mem_out_ready,
  output logic                                 mem_out_read_enable,
  output logic [ADDR_WIDTH-1:0]                mem_out_address,
  output logic [DATA_WIDTH-1:0]                mem_out_data,
  output logic [MASK_WIDTH-1:0]                mem_out_write_mask,
  output logic [OUT_ID_WIDTH-1:0]              mem_out_id,
  input  logic                                 resp_in_valid,
  output logic                                 resp_in_ready,
  input  logic [DATA_WIDTH-1:0]                resp_in_data,
  input  logic [OUT_ID_WIDTH-1:0]              resp_in_id,
  output logic [PORTS-1:0]                     resp_out_valid,
  input  logic [PORTS-1:0]                     resp_out_ready,
  output logic [PORTS-1:0][DATA_WIDTH-1:0]     resp_out_data,
  output logic [PORTS-1:0][ID_WIDTH-1:0]       resp_out_id,
  output logic                                 resp_err
);
  typedef struct packed {
    logic                    re;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [MASK_WIDTH-1:0]   mask;
    logic [OUT_ID_WIDTH-1:0] id;
  } req_t;

  logic [PORTS-1:0]  full, elig, hit;
  logic [PORT_W-1:0] gnt, rr_ptr, rp;
  logic              gnt_vld, load, accept, out_vld, tag_ok;
  req_t              sel, out_q;

  assign load   = !out_vld || mem_out_ready;
  assign accept = gnt_vld && load && !rst;
  assign rp     = resp_in_id[OUT_ID_WIDTH-1 -: PORT_W];
  assign tag_ok = |hit;

  // Scan order starts at the RR pointer in round-robin mode, at port 0 otherwise.
  always_comb begin
    logic [PORT_W-1:0] k;
    k       = '0;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      k = (ARB_MODE == 1) ? PORT_W'((int'(rr_ptr) + i) % PORTS) : PORT_W'(i);
      if (!gnt_vld && elig[k]) begin
        gnt_vld = 1'b1;
        gnt     = k;
      end
    end
  end

  always_comb begin
    sel.re   = mem_in_read_enable[gnt];
    sel.addr = mem_in_address[gnt];
    sel.data = mem_in_data[gnt];
    sel.mask = mem_in_write_mask[gnt];
    sel.id   = {gnt, mem_in_id[gnt]};
  end

  for (genvar k = 0; k < PORTS; k++) begin : g_lane
    mem_merge_port_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (mem_in_ready[k] && mem_in_read_enable[k]),
      .dec  (resp_out_valid[k] && resp_out_ready[k]),
      .full (full[k])
    );
    assign elig[k]           = mem_in_valid[k] && !(mem_in_read_enable[k] && full[k]);
    assign mem_in_ready[k]   = accept && (gnt == PORT_W'(k));
    assign hit[k]            = (rp == PORT_W'(k));
    assign resp_out_valid[k] = resp_in_valid && hit[k] && !rst;
    assign resp_out_data[k]  = resp_in_data;
    assign resp_out_id[k]    = resp_in_id[ID_WIDTH-1:0];
  end

  // Tags beyond the last port are swallowed so the memory side never blocks on them.
  assign resp_in_ready = tag_ok ? |(hit & resp_out_ready) : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      rr_ptr   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (load)   out_vld <= gnt_vld;
      if (accept) rr_ptr  <= (gnt == PORT_W'(PORTS - 1)) ? '0 : gnt + 1'b1;
      if (resp_in_valid && !tag_ok) resp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) out_q <= sel;
  end

  assign mem_out_valid       = out_vld;
  assign mem_out_read_enable = out_q.re;
  assign mem_out_address     = out_q.addr;
  assign mem_out_data        = out_q.data;
  assign mem_out_write_mask  = out_q.mask;
  assign mem_out_id          = out_q.id;
endmodule

// File: tb/tb_mem_merge_router.sv
// Random traffic against a cycle-level reference model (4-port round robin), plus directed
// fixed-priority, throttle, stall, invalid-tag and reset checks on a 3-port instance.

module tb_mem_merge_router;
  localparam int AP = 4, BP = 3, AW = 32, DW = 32, MW = 4, IW = 1, OW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Instance A: 4 ports, round robin, 4 outstanding
  logic a_rst;
  logic [AP-1:0] a_in_valid, a_in_ready, a_in_re;
  logic [AP-1:0][AW-1:0] a_in_addr;
  logic [AP-1:0][DW-1:0] a_in_data;
  logic [AP-1:0][MW-1:0] a_in_mask;
  logic [AP-1:0][IW-1:0] a_in_id;
  logic a_out_valid, a_out_ready, a_out_re;
  logic [AW-1:0] a_out_addr;
  logic [DW-1:0] a_out_data;
  logic [MW-1:0] a_out_mask;
  logic [OW-1:0] a_out_id;
  logic a_rin_valid, a_rin_ready;
  logic [DW-1:0] a_rin_data;
  logic [OW-1:0] a_rin_id;
  logic [AP-1:0] a_rout_valid, a_rout_ready;
  logic [AP-1:0][DW-1:0] a_rout_data;
  logic [AP-1:0][IW-1:0] a_rout_id;
  logic a_err;

  mem_merge_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .PORTS(AP),
                     .ARB_MODE(1), .MAX_OUTSTANDING(4)) u_a (
    .clk(clk), .rst(a_rst),
    .mem_in_valid(a_in_valid), .mem_in_ready(a_in_ready), .mem_in_read_enable(a_in_re),
    .mem_in_address(a_in_addr), .mem_in_data(a_in_data), .mem_in_write_mask(a_in_mask),
    .mem_in_id(a_in_id),
    .mem_out_valid(a_out_valid), .mem_out_ready(a_out_ready), .mem_out_read_enable(a_out_re),
    .mem_out_address(a_out_addr), .mem_out_data(a_out_data), .mem_out_write_mask(a_out_mask),
    .mem_out_id(a_out_id),
    .resp_in_valid(a_rin_valid), .resp_in_ready(a_rin_ready), .resp_in_data(a_rin_data),
    .resp_in_id(a_rin_id),
    .resp_out_valid(a_rout_valid), .resp_out_ready(a_rout_ready), .resp_out_data(a_rout_data),
    .resp_out_id(a_rout_id), .resp_err(a_err));

  // Instance B: 3 ports (one unused tag value), fixed priority, 2 outstanding
  logic b_rst;
  logic [BP-1:0] b_in_valid, b_in_ready, b_in_re;
  logic [BP-1:0][AW-1:0] b_in_addr;
  logic [BP-1:0][DW-1:0] b_in_data;
  logic [BP-1:0][MW-1:0] b_in_mask;
  logic [BP-1:0][IW-1:0] b_in_id;
  logic b_out_valid, b_out_ready, b_out_re;
  logic [AW-1:0] b_out_addr;
  logic [DW-1:0] b_out_data;
  logic [MW-1:0] b_out_mask;
  logic [OW-1:0] b_out_id;
  logic b_rin_valid, b_rin_ready;
  logic [DW-1:0] b_rin_data;
  logic [OW-1:0] b_rin_id;
  logic [BP-1:0] b_rout_valid, b_rout_ready;
  logic [BP-1:0][DW-1:0] b_rout_data;
  logic [BP-1:0][IW-1:0] b_rout_id;
  logic b_err;

  mem_merge_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .PORTS(BP),
                     .ARB_MODE(0), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst(b_rst),
    .mem_in_valid(b_in_valid), .mem_in_ready(b_in_ready), .mem_in_read_enable(b_in_re),
    .mem_in_address(b_in_addr), .mem_in_data(b_in_data), .mem_in_write_mask(b_in_mask),
    .mem_in_id(b_in_id),
    .mem_out_valid(b_out_valid), .mem_out_ready(b_out_ready), .mem_out_read_enable(b_out_re),
    .mem_out_address(b_out_addr), .mem_out_data(b_out_data), .mem_out_write_mask(b_out_mask),
    .mem_out_id(b_out_id),
    .resp_in_valid(b_rin_valid), .resp_in_ready(b_rin_ready), .resp_in_data(b_rin_data),
    .resp_in_id(b_rin_id),
    .resp_out_valid(b_rout_valid), .resp_out_ready(b_rout_ready), .resp_out_data(b_rout_data),
    .resp_out_id(b_rout_id), .resp_err(b_err));

  // Reference model state for instance A
  logic          mv, m_re;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [MW-1:0] m_mask;
  logic [OW-1:0] m_id;
  int            mptr;
  int            mcnt[AP];
  logic [OW-1:0] oq[$];
  logic [AP-1:0] hold;
  logic          rhold, rspur;
  int            ridx;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = '0; a_in_re = '0; a_in_addr = '0; a_in_data = '0; a_in_mask = '0; a_in_id = '0;
    a_out_ready = 1'b0; a_rin_valid = 1'b0; a_rin_data = '0; a_rin_id = '0; a_rout_ready = '0;
    b_in_valid = '0; b_in_re = '0; b_in_data = '0; b_in_mask = '0; b_in_id = '0;
    for (int k = 0; k < BP; k++) b_in_addr[k] = 32'h100 + k;
    b_out_ready = 1'b0; b_rin_valid = 1'b0; b_rin_data = '0; b_rin_id = '0; b_rout_ready = '0;
    mv = 1'b0; m_re = 1'b0; m_addr = '0; m_data = '0; m_mask = '0; m_id = '0; mptr = 0;
    for (int k = 0; k < AP; k++) mcnt[k] = 0;
    hold = '0; rhold = 1'b0; rspur = 1'b0; ridx = 0;

    // Reset state with live inputs
    @(negedge clk);
    a_in_valid = '1; a_rin_valid = 1'b1; a_rout_ready = '1;
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_rout_valid", a_rout_valid, 0);
    chk("rst_err", a_err, 0);
    @(negedge clk);
    a_in_valid = '0; a_rin_valid = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;

    // Random traffic on A
    for (int c = 0; c < 3000; c++) begin
      int g, p;
      bit found, load, racc;
      logic [AP-1:0] er, erv;
      @(negedge clk);
      a_rst = (c == 1500 || c == 1501);
      if (a_rst) begin
        mv = 1'b0; mptr = 0;
        for (int k = 0; k < AP; k++) mcnt[k] = 0;
      end
      for (int k = 0; k < AP; k++) begin
        if (!hold[k]) begin
          a_in_valid[k] = ($urandom % 4) != 0;
          a_in_re[k]    = $urandom % 2;
          a_in_addr[k]  = $urandom;
          a_in_data[k]  = $urandom;
          a_in_mask[k]  = 4'($urandom);
          a_in_id[k]    = 1'($urandom);
        end
      end
      a_out_ready  = ($urandom % 4) != 0;
      a_rout_ready = 4'($urandom | $urandom);
      if (a_rst) a_rin_valid = 1'b0;
      else if (rhold) a_rin_valid = 1'b1;
      else if (oq.size() > 0 && ($urandom % 3) == 0) begin
        ridx = $urandom_range(0, oq.size() - 1);
        a_rin_id = oq[ridx]; rspur = 1'b0; a_rin_valid = 1'b1; a_rin_data = $urandom;
      end else if (($urandom % 25) == 0) begin
        a_rin_id = 3'($urandom); rspur = 1'b1; a_rin_valid = 1'b1; a_rin_data = $urandom;
      end else a_rin_valid = 1'b0;
      #1;

      load = !mv || a_out_ready;
      found = 0; g = 0;
      for (int i = 0; i < AP; i++) begin
        int k;
        k = (mptr + i) % AP;
        if (!found && a_in_valid[k] && !(a_in_re[k] && mcnt[k] == 4)) begin
          found = 1; g = k;
        end
      end
      er = (found && load && !a_rst) ? 4'(1 << g) : 4'd0;
      p = int'(a_rin_id[2:1]);
      erv = a_rin_valid ? 4'(1 << p) : 4'd0;

      chk("in_ready", a_in_ready, er);
      chk("out_valid", a_out_valid, mv);
      if (mv) begin
        chk("out_re", a_out_re, m_re);
        chk("out_addr", a_out_addr, m_addr);
        chk("out_data", a_out_data, m_data);
        chk("out_mask", a_out_mask, m_mask);
        chk("out_id", a_out_id, m_id);
      end
      chk("rout_valid", a_rout_valid, erv);
      if (a_rin_valid) begin
        chk("rin_ready", a_rin_ready, a_rout_ready[p]);
        chk("rout_data", a_rout_data[p], a_rin_data);
        chk("rout_id", a_rout_id[p], a_rin_id[0]);
      end

      racc = a_rin_valid && a_rout_ready[p];
      if (mv && a_out_ready && m_re) oq.push_back(m_id);
      if (racc && !rspur) oq.delete(ridx);
      for (int k = 0; k < AP; k++) begin
        mcnt[k] = mcnt[k] + int'(er[k] && a_in_re[k]) - int'(racc && p == k);
        if (mcnt[k] < 0) mcnt[k] = 0;
      end
      if (load && !a_rst) begin
        mv = found;
        if (found) begin
          m_re = a_in_re[g]; m_addr = a_in_addr[g]; m_data = a_in_data[g];
          m_mask = a_in_mask[g]; m_id = {2'(g), a_in_id[g]};
          mptr = (g + 1) % AP;
        end
      end
      hold = a_in_valid & ~er;
      if (!a_rst) rhold = a_rin_valid && !racc;
    end
    chk("a_err_clear", a_err, 0);

    // B: reset state
    @(negedge clk);
    b_in_valid = 3'b111;
    #1;
    chk("b_rst_in_ready", b_in_ready, 0);
    chk("b_rst_out_valid", b_out_valid, 0);
    chk("b_rst_err", b_err, 0);
    @(negedge clk);
    b_in_valid = '0; b_rst = 1'b0;

    // Fixed priority: port 1 beats port 2 until it drops
    b_out_ready = 1'b1; b_rout_ready = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_in_valid = 3'b110;
      #1;
      chk("fp_ready", b_in_ready, 3'b010);
      if (i > 0) chk("fp_tag", b_out_id, 3'b010);
    end
    @(negedge clk);
    b_in_valid = 3'b100;
    #1;
    chk("fp_ready_p2", b_in_ready, 3'b100);
    @(negedge clk);
    b_in_valid = 3'b000;
    #1;
    chk("fp_tag_p2", b_out_id, 3'b100);
    chk("fp_addr_p2", b_out_addr, 32'h102);

    // Outstanding limit on port 0 (2 reads), port 2 writes still served
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b_in_valid = 3'b001; b_in_re = 3'b001;
      #1;
      chk("thr_fill", b_in_ready, 3'b001);
    end
    @(negedge clk);
    b_in_valid = 3'b101;
    #1;
    chk("thr_block", b_in_ready, 3'b100);
    @(negedge clk);
    b_rin_valid = 1'b1; b_rin_id = 3'b000; b_rin_data = 32'hCAFE_0001;
    #1;
    chk("thr_rout_valid", b_rout_valid, 3'b001);
    chk("thr_rout_data", b_rout_data[0], 32'hCAFE_0001);
    chk("thr_rin_ready", b_rin_ready, 1);
    chk("thr_still_block", b_in_ready, 3'b100);
    @(negedge clk);
    b_rin_valid = 1'b0;
    #1;
    chk("thr_release", b_in_ready, 3'b001);
    @(negedge clk);
    b_in_valid = '0; b_in_re = '0;

    // Output stall: payload held, all readies low, next grant loads on drain
    @(negedge clk);
    b_in_valid = 3'b010; b_in_addr[1] = 32'h55;
    #1;
    chk("stall_load", b_in_ready, 3'b010);
    @(negedge clk);
    b_in_valid = 3'b100; b_in_addr[2] = 32'h66; b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", b_in_ready, 3'b000);
      chk("stall_valid", b_out_valid, 1);
      chk("stall_addr", b_out_addr, 32'h55);
      @(negedge clk);
    end
    b_out_ready = 1'b1;
    #1;
    chk("drain_ready", b_in_ready, 3'b100);
    @(negedge clk);
    b_in_valid = '0;
    #1;
    chk("drain_addr", b_out_addr, 32'h66);
    chk("drain_tag", b_out_id, 3'b100);

    // Invalid tag 3 on a 3-port router: dropped and flagged
    @(negedge clk);
    b_rin_valid = 1'b1; b_rin_id = 3'b110; b_rout_ready = '0;
    #1;
    chk("bad_rin_ready", b_rin_ready, 1);
    chk("bad_rout_valid", b_rout_valid, 0);
    chk("bad_err_pre", b_err, 0);
    @(negedge clk);
    b_rin_valid = 1'b0;
    #1;
    chk("bad_err", b_err, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("bad_err_sticky", b_err, 1);

    // Reset in the middle of traffic
    @(negedge clk);
    b_in_valid = 3'b111; b_rin_valid = 1'b1; b_rin_id = 3'b010; b_rout_ready = '1;
    #1;
    chk("mid_rout_pre", b_rout_valid, 3'b010);
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    chk("mid_out_valid", b_out_valid, 0);
    chk("mid_in_ready", b_in_ready, 0);
    chk("mid_rout_valid", b_rout_valid, 0);
    chk("mid_err", b_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
